// File: rtl/gnn_0_save_scheduler.sv
// -----------------------------------------------------------------------------
// gnn_0_save_scheduler
//
// Instruction front-end and sequencer for the save unit. Save instructions are
// queued in a small FIFO, optionally gated on a compute->save dependency token,
// split into bounded row chunks and handed to the save unit one chunk at a time
// through an ap_start / ap_done handshake. Completion is counted and can
// release a token back upstream.
//
// Configuration macro:
//   SAVE_SCHED_CHUNK_EN  defined   : transfers are split into CHUNK_ROWS chunks
//                        undefined : the instruction is forwarded unchanged in
//                                    a single command
//
// Ports:
//   aclk, areset           clock, asynchronous active-low reset
//   inst_valid/ready/data  instruction push interface (ready = FIFO not full)
//   save_ap_start          one-cycle start pulse to the save unit
//   save_ctrl_instruction  command to the save unit, held until the next start
//   save_ap_done           save unit completion pulse
//   dep_token_in           one result tile ready (pulse)
//   dep_token_out          pulse after a REL instruction fully completes
//   busy                   sequencer active or instructions queued
//   inst_done_count        completed instruction count (wraps)
//   token_overflow         sticky: token arrived while the counter was full
// -----------------------------------------------------------------------------
module gnn_0_save_scheduler #(
  parameter int SAVE_INST_LENGTH = 96,
  parameter int FIFO_DEPTH       = 4,
  parameter int CHUNK_ROWS       = 16,
  parameter int TOKEN_WIDTH      = 4
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        inst_valid,
  output logic                        inst_ready,
  input  logic [SAVE_INST_LENGTH-1:0] inst_data,
  output logic                        save_ap_start,
  output logic [SAVE_INST_LENGTH-1:0] save_ctrl_instruction,
  input  logic                        save_ap_done,
  input  logic                        dep_token_in,
  output logic                        dep_token_out,
  output logic                        busy,
  output logic [31:0]                 inst_done_count,
  output logic                        token_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [TOKEN_WIDTH-1:0] TOKEN_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT_DEP, S_ISSUE, S_WAIT_DONE, S_FINISH
  } state_t;

  state_t                      state;
  logic [SAVE_INST_LENGTH-1:0] cur_inst;
  logic [TOKEN_WIDTH-1:0]      token_cnt;

  // ---------------------------------------------------------------------------
  // Instruction FIFO
  // ---------------------------------------------------------------------------
  logic [SAVE_INST_LENGTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr, rd_ptr;
  logic [CNT_W-1:0]            fifo_count, fifo_count_next;
  logic                        push, pop, busy_next, consume, size_zero;

  assign push      = inst_valid && inst_ready;
  assign pop       = (state == S_IDLE) && (fifo_count != '0);
  assign consume   = (state == S_WAIT_DEP) && (token_cnt != '0);
  assign size_zero = (cur_inst[63:48] == 16'd0);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    fifo_count_next = fifo_count;
    if (push && !pop)      fifo_count_next = fifo_count + CNT_W'(1);
    else if (pop && !push) fifo_count_next = fifo_count - CNT_W'(1);
  end

  // The FSM returns to IDLE only from FINISH, or stays there when nothing pops.
  assign busy_next = !((state == S_FINISH) || ((state == S_IDLE) && !pop)) ||
                     (fifo_count_next != '0);

  // NOTE: storage is not reset; only the pointers and count define validity,
  // and a reset on the array would cost a flop-based memory for nothing.
  always_ff @(posedge aclk) begin
    if (push) fifo_mem[wr_ptr] <= inst_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      inst_ready <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count_next;
      inst_ready <= (fifo_count_next != CNT_W'(FIFO_DEPTH));
      busy       <= busy_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Dependency token counter (saturating; simultaneous inc+dec cancels out)
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      token_cnt      <= '0;
      token_overflow <= 1'b0;
    end else begin
      unique case ({dep_token_in, consume})
        2'b10: begin
          if (token_cnt == TOKEN_MAX) token_overflow <= 1'b1;
          else                        token_cnt      <= token_cnt + TOKEN_WIDTH'(1);
        end
        2'b01:   token_cnt <= token_cnt - TOKEN_WIDTH'(1);
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Chunk bookkeeping
  // ---------------------------------------------------------------------------
`ifdef SAVE_SCHED_CHUNK_EN
  localparam logic [15:0] CHUNK_LEN = 16'(CHUNK_ROWS);
  logic [15:0] remaining, buf_ptr, dram_ptr, chunk_len;
  logic        unused_dram_size;

  // The original DRAM_SIZE is superseded by the per-chunk length.
  assign unused_dram_size = ^cur_inst[95:80];
  assign chunk_len        = (remaining < CHUNK_LEN) ? remaining : CHUNK_LEN;
`else
  localparam int unused_chunk_rows = CHUNK_ROWS;
`endif

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      state                 <= S_IDLE;
      cur_inst              <= '0;
      save_ap_start         <= 1'b0;
      save_ctrl_instruction <= '0;
      dep_token_out         <= 1'b0;
      inst_done_count       <= '0;
`ifdef SAVE_SCHED_CHUNK_EN
      remaining             <= '0;
      buf_ptr               <= '0;
      dram_ptr              <= '0;
`endif
    end else begin
      save_ap_start <= 1'b0;
      dep_token_out <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            cur_inst <= fifo_mem[rd_ptr];
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
`ifdef SAVE_SCHED_CHUNK_EN
          remaining <= cur_inst[63:48];
          buf_ptr   <= cur_inst[47:32];
          dram_ptr  <= cur_inst[79:64];
`endif
          if (cur_inst[0])    state <= S_WAIT_DEP;
          else if (size_zero) state <= S_FINISH;
          else                state <= S_ISSUE;
        end
        S_WAIT_DEP: begin
          if (consume) state <= size_zero ? S_FINISH : S_ISSUE;
        end
        S_ISSUE: begin
          save_ap_start <= 1'b1;
`ifdef SAVE_SCHED_CHUNK_EN
          save_ctrl_instruction <= {chunk_len, dram_ptr, chunk_len, buf_ptr,
                                    cur_inst[31:0]};
`else
          save_ctrl_instruction <= cur_inst;
`endif
          state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (save_ap_done) begin
`ifdef SAVE_SCHED_CHUNK_EN
            remaining <= remaining - chunk_len;
            buf_ptr   <= buf_ptr + chunk_len;
            dram_ptr  <= dram_ptr + chunk_len;
            state     <= (remaining == chunk_len) ? S_FINISH : S_ISSUE;
`else
            state     <= S_FINISH;
`endif
          end
        end
        S_FINISH: begin
          inst_done_count <= inst_done_count + 32'd1;
          dep_token_out   <= cur_inst[1];
          state           <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gnn_0_save_scheduler.sv
// -----------------------------------------------------------------------------
// tb_gnn_0_save_scheduler
//
// Directed bench for gnn_0_save_scheduler. A behavioural save unit answers
// every save_ap_start with save_ap_done after done_delay cycles and logs the
// commands, start/done cycles and dep_token_out pulses for the checks.
// Chunk expectations follow SAVE_SCHED_CHUNK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_gnn_0_save_scheduler;

  logic        aclk = 1'b0;
  logic        areset = 1'b0;
  logic        inst_valid = 1'b0;
  logic [95:0] inst_data = '0;
  logic        save_ap_done;
  logic        dep_token_in = 1'b0;
  logic        inst_ready, save_ap_start, dep_token_out, busy, token_overflow;
  logic [95:0] save_ctrl_instruction;
  logic [31:0] inst_done_count;

  gnn_0_save_scheduler #(
    .SAVE_INST_LENGTH(96), .FIFO_DEPTH(4), .CHUNK_ROWS(16), .TOKEN_WIDTH(4)
  ) dut (
    .aclk                  (aclk),
    .areset                (areset),
    .inst_valid            (inst_valid),
    .inst_ready            (inst_ready),
    .inst_data             (inst_data),
    .save_ap_start         (save_ap_start),
    .save_ctrl_instruction (save_ctrl_instruction),
    .save_ap_done          (save_ap_done),
    .dep_token_in          (dep_token_in),
    .dep_token_out         (dep_token_out),
    .busy                  (busy),
    .inst_done_count       (inst_done_count),
    .token_overflow        (token_overflow)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc++;

  int n_checks = 0;
  int n_errors = 0;

  logic [95:0] cmd_q[$];
  int          start_q[$];
  int          done_q[$];
  int          tok_q[$];
  int          done_delay = 3;
  int          pend = 0;
  bit          force_done = 1'b0;
  int          last_acc = 0;

  task automatic check(input string tag, input logic [95:0] got,
                       input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] mk(input logic [15:0] dsz, input logic [15:0] dst,
                                     input logic [15:0] bsz, input logic [15:0] bst,
                                     input logic [29:0] tag, input logic rel,
                                     input logic dep);
    return {dsz, dst, bsz, bst, tag, rel, dep};
  endfunction

  function automatic logic [95:0] chunk_cmd(input logic [15:0] len,
                                            input logic [15:0] dram,
                                            input logic [15:0] bptr,
                                            input logic [31:0] low);
    return {len, dram, len, bptr, low};
  endfunction

  // Behavioural save unit and output monitor.
  initial begin
    save_ap_done = 1'b0;
    forever begin
      @(negedge aclk);
      save_ap_done = 1'b0;
      if (!areset) begin
        pend = 0;
      end else begin
        if (dep_token_out) tok_q.push_back(cyc);
        if (save_ap_start) begin
          cmd_q.push_back(save_ctrl_instruction);
          start_q.push_back(cyc);
          pend = done_delay;
        end else if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            save_ap_done = 1'b1;
            done_q.push_back(cyc);
          end
        end
        if (force_done) begin
          save_ap_done = 1'b1;
          force_done   = 1'b0;
        end
      end
    end
  end

  task automatic clear_logs();
    cmd_q.delete(); start_q.delete(); done_q.delete(); tok_q.delete();
  endtask

  task automatic push(input logic [95:0] d);
    bit   ok;
    logic rdy;
    ok = 1'b0;
    inst_valid = 1'b1;
    inst_data  = d;
    for (int i = 0; i < 200; i++) begin
      rdy = inst_ready;
      @(posedge aclk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    inst_valid = 1'b0;
    last_acc   = cyc;
    check("push_accept", ok, 1);
  endtask

  task automatic wait_idle(input int max, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge aclk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, ok, 1);
    repeat (2) @(negedge aclk);
  endtask

  task automatic do_reset();
    @(negedge aclk);
    areset = 1'b0;
    repeat (2) @(negedge aclk);
    areset = 1'b1;
    repeat (2) @(negedge aclk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [95:0] i1, i2, i3, ir;
    logic [95:0] exp_cmd [3];

    // ---------------- reset values ----------------
    repeat (3) @(negedge aclk);
    check("rst_ready", inst_ready, 0);
    check("rst_start", save_ap_start, 0);
    check("rst_ctrl", save_ctrl_instruction, 0);
    check("rst_tok_out", dep_token_out, 0);
    check("rst_busy", busy, 0);
    check("rst_count", inst_done_count, 0);
    check("rst_ovf", token_overflow, 0);
    areset = 1'b1;
    @(negedge aclk);
    check("ready_after_rst", inst_ready, 1);

    // ---------------- test 1: single chunk, latency ----------------
    clear_logs();
    i1 = mk(16'h0033, 16'h0200, 16'h0010, 16'h0100, 30'h2AB, 1'b0, 1'b0);
    push(i1);
    wait_idle(100, "t1_idle");
    check("t1_ncmd", cmd_q.size(), 1);
`ifdef SAVE_SCHED_CHUNK_EN
    check("t1_cmd", cmd_q[0], chunk_cmd(16'h0010, 16'h0200, 16'h0100, i1[31:0]));
`else
    check("t1_cmd", cmd_q[0], i1);
`endif
    check("t1_cmd_63_32", cmd_q[0][63:32], 32'h0010_0100);
    check("t1_latency", start_q[0] - last_acc, 3);
    check("t1_count", inst_done_count, 1);
    check("t1_no_tok", tok_q.size(), 0);

    // ---------------- test 2: chunking with pointer wrap ----------------
    clear_logs();
    i2 = mk(16'h0099, 16'h1000, 16'd40, 16'hFFF8, 30'h155, 1'b0, 1'b0);
    push(i2);
    wait_idle(200, "t2_idle");
`ifdef SAVE_SCHED_CHUNK_EN
    exp_cmd[0] = chunk_cmd(16'd16, 16'h1000, 16'hFFF8, i2[31:0]);
    exp_cmd[1] = chunk_cmd(16'd16, 16'h1010, 16'h0008, i2[31:0]);
    exp_cmd[2] = chunk_cmd(16'd8,  16'h1020, 16'h0018, i2[31:0]);
    check("t2_ncmd", cmd_q.size(), 3);
    for (int k = 0; k < 3; k++) check($sformatf("t2_cmd%0d", k), cmd_q[k], exp_cmd[k]);
    check("t2_rechunk_gap", start_q[1] - done_q[0], 2);
`else
    check("t2_ncmd", cmd_q.size(), 1);
    check("t2_cmd", cmd_q[0], i2);
`endif
    check("t2_count", inst_done_count, 2);

    // ---------------- test 3: DEP wait and REL release ----------------
    clear_logs();
    i3 = mk(16'h0000, 16'h0400, 16'd8, 16'h0300, 30'h3C3, 1'b1, 1'b1);
    push(i3);
    repeat (20) @(negedge aclk);
    check("t3_blocked", cmd_q.size(), 0);
    check("t3_busy", busy, 1);
    dep_token_in = 1'b1;
    @(negedge aclk);
    dep_token_in = 1'b0;
    wait_idle(100, "t3_idle");
    check("t3_ncmd", cmd_q.size(), 1);
`ifdef SAVE_SCHED_CHUNK_EN
    check("t3_cmd", cmd_q[0], chunk_cmd(16'd8, 16'h0400, 16'h0300, i3[31:0]));
`else
    check("t3_cmd", cmd_q[0], i3);
`endif
    check("t3_ntok", tok_q.size(), 1);
    check("t3_tok_lat", tok_q[0] - done_q[done_q.size()-1], 2);
    check("t3_count", inst_done_count, 3);

    // ---------------- test 4: FIFO fill with stalled save unit ----------------
    clear_logs();
    done_delay = 30;
    for (int k = 0; k < 5; k++)
      push(mk(16'h0000, 16'h2000 + 16'(k * 16), 16'd4, 16'h0500, 30'(k), 1'b0, 1'b0));
    check("t4_full", inst_ready, 0);
    wait_idle(400, "t4_idle");
    check("t4_ncmd", cmd_q.size(), 5);
    for (int k = 0; k < 5; k++) check($sformatf("t4_order%0d", k), cmd_q[k][31:2], k);
    check("t4_count", inst_done_count, 8);
    done_delay = 3;

    // ---------------- test 5: token saturation ----------------
    clear_logs();
    @(negedge aclk);
    dep_token_in = 1'b1;
    repeat (15) @(negedge aclk);
    check("t5_ovf_at_15", token_overflow, 0);
    @(negedge aclk);
    dep_token_in = 1'b0;
    check("t5_ovf_at_16", token_overflow, 1);
    for (int k = 0; k < 16; k++)
      push(mk(16'h0, 16'h0, 16'h0, 16'h0, 30'(100 + k), 1'b0, 1'b1));
    repeat (20) @(negedge aclk);
    check("t5_saturated_count", inst_done_count, 8 + 15);
    check("t5_stuck_busy", busy, 1);
    check("t5_zero_size_no_cmd", cmd_q.size(), 0);
    // Token arrives on the same edge a waiting instruction consumes one.
    dep_token_in = 1'b1;
    repeat (2) @(negedge aclk);
    dep_token_in = 1'b0;
    push(mk(16'h0, 16'h0, 16'h0, 16'h0, 30'd200, 1'b0, 1'b1));
    push(mk(16'h0, 16'h0, 16'h0, 16'h0, 30'd201, 1'b0, 1'b1));
    repeat (20) @(negedge aclk);
    check("t5_simul_inc_dec", inst_done_count, 8 + 17);
    check("t5_last_stuck", busy, 1);

    // ---------------- test 6: reset during WAIT_DONE ----------------
    do_reset();
    check("t6_ovf_cleared", token_overflow, 0);
    check("t6_count_cleared", inst_done_count, 0);
    clear_logs();
    done_delay = 30;
    ir = mk(16'h0000, 16'h0600, 16'd4, 16'h0700, 30'h077, 1'b1, 1'b0);
    push(ir);
    push(mk(16'h0000, 16'h0800, 16'd4, 16'h0900, 30'h088, 1'b0, 1'b0));
    repeat (8) @(negedge aclk);
    check("t6_issued", cmd_q.size(), 1);
    areset = 1'b0;
    #1;
    check("t6_ready", inst_ready, 0);
    check("t6_start", save_ap_start, 0);
    check("t6_ctrl", save_ctrl_instruction, 0);
    check("t6_tok_out", dep_token_out, 0);
    check("t6_busy", busy, 0);
    check("t6_count", inst_done_count, 0);
    repeat (2) @(negedge aclk);
    areset = 1'b1;
    done_delay = 3;
    repeat (3) @(negedge aclk);
    check("t6_ready_after", inst_ready, 1);
    clear_logs();
    force_done = 1'b1;
    repeat (10) @(negedge aclk);
    check("t6_stray_busy", busy, 0);
    check("t6_stray_count", inst_done_count, 0);
    check("t6_fifo_emptied", cmd_q.size(), 0);
    check("t6_stray_no_tok", tok_q.size(), 0);
    push(ir);
    wait_idle(100, "t6_idle");
    check("t6_post_count", inst_done_count, 1);
    check("t6_post_tok", tok_q.size(), 1);
`ifdef SAVE_SCHED_CHUNK_EN
    check("t6_post_cmd", cmd_q[0], chunk_cmd(16'd4, 16'h0600, 16'h0700, ir[31:0]));
`else
    check("t6_post_cmd", cmd_q[0], ir);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
